// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
//   rx_state_t   - receiver frame FSM states
//   MIN_PRESCALE - smallest usable clocks-per-bit (needs 3 distinct samples)
//   MAX_DATA_W   - widest supported data word
//   parity()     - expected parity bit for a data word (typ 0 even, 1 odd)
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam int MIN_PRESCALE = 4;
   localparam int MAX_DATA_W   = 9;

   // Narrower words are zero-extended by the caller, which leaves XOR unchanged.
   function automatic logic parity(input logic [MAX_DATA_W-1:0] data, input logic typ);
      return (^data) ^ typ;
   endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word ready/valid channel plus error pulses.
//   master (receiver): drives P_DATA, data_valid, par_err, stp_err, overrun
//   slave  (consumer): drives data_ready
interface uart_rx_param_if #(parameter int DATA_W = 8) ();

   logic [DATA_W-1:0] P_DATA;
   logic              data_valid;
   logic              data_ready;
   logic              par_err;
   logic              stp_err;
   logic              overrun;

   modport master (output P_DATA, data_valid, par_err, stp_err, overrun,
                   input  data_ready);
   modport slave  (input  P_DATA, data_valid, par_err, stp_err, overrun,
                   output data_ready);

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop synchronizer, per-bit edge counter and 3-sample
// majority vote.
//   rx_in   async serial line (idle high)
//   run     frame in progress; edge counter held at 0 otherwise
//   presc   latched clocks-per-bit P (already clamped to >= 4)
//   rxs     synchronized line
//   bit_end edge_cnt == P-1 this cycle (bit decision point)
//   vote    majority of rxs at edge_cnt P/2-1, P/2, P/2+1
module uart_rx_sampler #(
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic               run,
   input  logic [PRESC_W-1:0] presc,
   output logic               rxs,
   output logic               bit_end,
   output logic               vote
);

   logic               sync1, sync2;
   logic [PRESC_W-1:0] edge_cnt;
   logic [PRESC_W-1:0] mid, lo, hi;
   logic               s0, s1, s2, s2_now;

   assign mid     = presc >> 1;
   assign lo      = mid - PRESC_W'(1);
   assign hi      = mid + PRESC_W'(1);
   assign rxs     = sync2;
   assign bit_end = run && (edge_cnt == presc - PRESC_W'(1));

   // With P=4 the last sample point coincides with the decision cycle, so the
   // live synced bit is used instead of the not-yet-written register.
   assign s2_now = (edge_cnt == hi) ? sync2 : s2;
   assign vote   = (s0 & s1) | (s0 & s2_now) | (s1 & s2_now);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         edge_cnt <= '0;
         s0       <= 1'b1;
         s1       <= 1'b1;
         s2       <= 1'b1;
      end else begin
         sync1 <= rx_in;
         sync2 <= sync1;
         if (!run || bit_end) edge_cnt <= '0;
         else                 edge_cnt <= edge_cnt + PRESC_W'(1);
         if (run && edge_cnt == lo)  s0 <= sync2;
         if (run && edge_cnt == mid) s1 <= sync2;
         if (run && edge_cnt == hi)  s2 <= sync2;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (DATA_W data bits LSB first,
// optional parity, one or two stop bits, runtime oversampling).
//   clk, rst          clock, async active-low reset
//   RX_IN             async serial line, idle high
//   PRESCALE          clocks per bit (values < 4 treated as 4)
//   PAR_EN, PAR_TYP   parity present / 0 even, 1 odd
//   STOP2             two stop bits expected
//   bus (master)      P_DATA/data_valid/data_ready holding register and
//                     par_err/stp_err/overrun one-cycle pulses
// Config inputs are latched at frame start; mid-frame changes are ignored.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] PRESCALE,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic               STOP2,
   uart_rx_param_if.master    bus
);

   rx_state_t          state;
   logic [3:0]         bit_cnt;
   logic [DATA_W-1:0]  shreg;
   logic               stop_cnt;
   logic               par_bad, stp_bad;
   logic [PRESC_W-1:0] cfg_presc;
   logic               cfg_par_en, cfg_par_typ, cfg_stop2;
   logic [PRESC_W-1:0] presc_clamped;
   logic               rxs, bit_end, vote;
   logic               last_stp_bad;

   assign presc_clamped = (PRESCALE < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE)
                                                               : PRESCALE;
   assign last_stp_bad  = stp_bad | ~vote;

   uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
      .clk     (clk),
      .rst     (rst),
      .rx_in   (RX_IN),
      .run     (state != IDLE),
      .presc   (cfg_presc),
      .rxs     (rxs),
      .bit_end (bit_end),
      .vote    (vote)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shreg          <= '0;
         stop_cnt       <= 1'b0;
         par_bad        <= 1'b0;
         stp_bad        <= 1'b0;
         cfg_presc      <= PRESC_W'(MIN_PRESCALE);
         cfg_par_en     <= 1'b0;
         cfg_par_typ    <= 1'b0;
         cfg_stop2      <= 1'b0;
         bus.P_DATA     <= '0;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stp_err    <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.par_err <= 1'b0;
         bus.stp_err <= 1'b0;
         bus.overrun <= 1'b0;
         // A word loaded below in the same cycle overrides this clear.
         if (bus.data_valid && bus.data_ready) bus.data_valid <= 1'b0;

         case (state)
            IDLE: if (!rxs) begin
               state       <= START;
               cfg_presc   <= presc_clamped;
               cfg_par_en  <= PAR_EN;
               cfg_par_typ <= PAR_TYP;
               cfg_stop2   <= STOP2;
            end
            START: if (bit_end) begin
               if (vote) state <= IDLE;   // start glitch: silently drop
               else begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  par_bad <= 1'b0;
                  stp_bad <= 1'b0;
               end
            end
            DATA: if (bit_end) begin
               shreg <= {vote, shreg[DATA_W-1:1]};
               if (bit_cnt == 4'(DATA_W-1)) begin
                  state    <= cfg_par_en ? PARITY : STOP;
                  stop_cnt <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            PARITY: if (bit_end) begin
               par_bad <= (vote != parity(MAX_DATA_W'(shreg), cfg_par_typ));
               state   <= STOP;
            end
            STOP: if (bit_end) begin
               if (cfg_stop2 && !stop_cnt) begin
                  stop_cnt <= 1'b1;
                  if (!vote) stp_bad <= 1'b1;
               end else begin
                  state       <= IDLE;
                  bus.par_err <= par_bad;
                  bus.stp_err <= last_stp_bad;
                  if (!par_bad && !last_stp_bad) begin
                     if (!bus.data_valid || bus.data_ready) begin
                        bus.P_DATA     <= shreg;
                        bus.data_valid <= 1'b1;
                     end else begin
                        bus.overrun <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomized scoreboard bench for uart_rx_param. Stimulus pushes the expected
// outcome of each frame (word, error flags or overrun); an independent monitor
// pops and compares whenever the DUT presents a new word or pulses a flag.
module tb_uart_rx_param;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] PRESCALE = 6'd16;
   logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;

   uart_rx_param_if #(.DATA_W(DW)) bus ();

   uart_rx_param #(.DATA_W(DW), .PRESC_W(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .RX_IN    (RX_IN),
      .PRESCALE (PRESCALE),
      .PAR_EN   (PAR_EN),
      .PAR_TYP  (PAR_TYP),
      .STOP2    (STOP2),
      .bus      (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          is_word;
      logic [DW-1:0] data;
      logic          pe, se, ov;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0, n_bad = 0;
   bit  holding = 0;   // model: a delivered word is still waiting for the consumer

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic          prev_valid = 0, prev_acc = 0, new_word;
   logic [DW-1:0] held;
   ev_t           e;

   always @(negedge clk) begin
      if (!rst) begin
         prev_valid = 0;
         prev_acc   = 0;
      end else begin
         new_word = bus.data_valid && !(prev_valid && !prev_acc);
         if (prev_valid && !prev_acc && bus.data_valid)
            chk("hold_stable", 32'(bus.P_DATA), 32'(held));
         if (new_word || bus.par_err || bus.stp_err || bus.overrun) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_event: word=%0b data=%0h pe=%0b se=%0b ov=%0b at %0t",
                        new_word, bus.P_DATA, bus.par_err, bus.stp_err, bus.overrun, $time);
            end else begin
               e = exp_q.pop_front();
               chk("ev_word", 32'(new_word), 32'(e.is_word));
               if (e.is_word) chk("ev_data", 32'(bus.P_DATA), 32'(e.data));
               chk("ev_par_err", 32'(bus.par_err), 32'(e.pe));
               chk("ev_stp_err", 32'(bus.stp_err), 32'(e.se));
               chk("ev_overrun", 32'(bus.overrun), 32'(e.ov));
            end
         end
         held       = bus.P_DATA;
         prev_valid = bus.data_valid;
         prev_acc   = bus.data_valid && bus.data_ready;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Sends one frame. pbit is the parity bit put on the line (if parity on),
   // sb1/sb2 the stop bit values, glitch_bit inverts one mid-bit cycle of that
   // frame bit index (-1 for none). expect_it=0 for frames that will be aborted.
   task automatic send_frame(input logic [DW-1:0] d, input int presc, input logic pen,
                             input logic ptyp, input logic st2, input logic pbit,
                             input logic sb1, input logic sb2, input int glitch_bit,
                             input bit expect_it);
      int   p;
      int   ones;
      logic bits[$];
      ev_t  ev;
      p = (presc < 4) ? 4 : presc;
      if (expect_it) begin
         ones  = $countones(d) + int'(pbit);
         ev.pe = pen && ((ones % 2) != int'(ptyp));
         ev.se = !sb1 || (st2 && !sb2);
         ev.data = d;
         ev.is_word = 0;
         ev.ov = 0;
         if (!ev.pe && !ev.se) begin
            if (holding) ev.ov = 1;
            else begin
               ev.is_word = 1;
               holding = !bus.data_ready;
            end
         end
         exp_q.push_back(ev);
      end
      PRESCALE = PW'(presc); PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(sb1);
      if (st2) bits.push_back(sb2);
      for (int bi = 0; bi < bits.size(); bi++) begin
         for (int c = 0; c < p; c++) begin
            @(posedge clk); #1;
            RX_IN = (bi == glitch_bit && c == p/2 + 1) ? ~bits[bi] : bits[bi];
            if (bi == 1 && c == 0) begin   // scramble config mid-frame
               PRESCALE = PW'($urandom);
               PAR_EN   = 1'($urandom);
               PAR_TYP  = 1'($urandom);
               STOP2    = 1'($urandom);
            end
         end
      end
      @(posedge clk); #1;
      RX_IN = 1'b1;
   endtask

   initial begin
      int w;
      logic [DW-1:0] rd;
      logic pen, pt, s2;
      bus.data_ready = 1'b1;
      idle(3);
      @(negedge clk);
      chk("rst_P_DATA", 32'(bus.P_DATA), 0);
      chk("rst_valid", 32'(bus.data_valid), 0);
      chk("rst_par_err", 32'(bus.par_err), 0);
      chk("rst_stp_err", 32'(bus.stp_err), 0);
      chk("rst_overrun", 32'(bus.overrun), 0);
      @(posedge clk); #1 rst = 1'b1;
      idle(5);

      // 1: plain frame
      send_frame(8'hA5, 16, 0, 0, 0, 0, 1, 1, -1, 1);
      idle(20);
      // 2: odd parity with wrong parity bit on the line
      send_frame(8'h3C, 8, 1, 1, 0, 0, 1, 1, -1, 1);
      idle(20);
      // 3: second stop bit low, then a good frame straight after
      send_frame(8'h55, 16, 0, 0, 1, 0, 1, 0, -1, 1);
      send_frame(8'h12, 16, 0, 0, 0, 0, 1, 1, -1, 1);
      idle(20);
      // 4: consumer stalled -> second frame overruns
      bus.data_ready = 1'b0;
      send_frame(8'h11, 8, 0, 0, 0, 0, 1, 1, -1, 1);
      idle(4);
      send_frame(8'h22, 8, 0, 0, 0, 0, 1, 1, -1, 1);
      idle(20);
      @(negedge clk);
      chk("ovr_held_valid", 32'(bus.data_valid), 1);
      chk("ovr_held_data", 32'(bus.P_DATA), 32'h11);
      @(posedge clk); #1 bus.data_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ovr_valid_drop", 32'(bus.data_valid), 0);
      holding = 0;
      // 5: short low glitch on idle line, then 0x00 with a mid-bit 1 glitch
      PRESCALE = 6'd16;
      @(posedge clk); #1 RX_IN = 1'b0;
      idle(3); #1 RX_IN = 1'b1;
      idle(60);
      send_frame(8'h00, 16, 0, 0, 0, 0, 1, 1, 4, 1);
      idle(20);
      // 6: reset during data bits of 0xF0, held through the rest of that frame
      fork
         send_frame(8'hF0, 16, 0, 0, 0, 0, 1, 1, -1, 0);
         begin idle(16*3 + 8); #1 rst = 1'b0; end
      join
      idle(5);
      @(negedge clk);
      chk("midrst_valid", 32'(bus.data_valid), 0);
      chk("midrst_P_DATA", 32'(bus.P_DATA), 0);
      @(posedge clk); #1 rst = 1'b1;
      idle(5);
      send_frame(8'h0F, 16, 0, 0, 0, 0, 1, 1, -1, 1);
      idle(20);

      // random frames, consumer always ready
      for (int k = 0; k < 40; k++) begin
         rd  = DW'($urandom);
         pen = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
         send_frame(rd, int'($urandom_range(2, 20)), pen, pt, s2, 1'($urandom),
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), -1, 1);
         idle(int'($urandom_range(1, 4)));
      end

      w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      chk("drain_pending", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
